// File: rtl/dpram_init_pkg.sv
// rtl/dpram_init_pkg.sv - shared constants for the self-initialising dual-port RAM
package dpram_init_pkg;

    localparam int WRITE_FIRST = 0;
    localparam int READ_FIRST  = 1;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

endpackage

// File: rtl/dpram_rd_pipe.sv
// rtl/dpram_rd_pipe.sv - read-data/valid delay line; data stages only load behind a valid
module dpram_rd_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [RD_LATENCY-1:0] vld;
    logic [DATA_WIDTH-1:0] dat [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            if (in_valid) begin
                dat[0] <= in_data;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    assign rvalid = vld[RD_LATENCY-1];
    assign rdata  = dat[RD_LATENCY-1];

endmodule

// File: rtl/dpram_init.sv
// rtl/dpram_init.sv - true dual-port RAM with byte lanes and a hardware init sweep
module dpram_init
    import dpram_init_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    BYTE_WIDTH = 8,
    parameter int                    RD_LATENCY = 1,
    parameter int                    RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear_req,
    input  logic                               en_a,
    input  logic                               en_b,
    input  logic                               we_a,
    input  logic                               we_b,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   be_a,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   be_b,
    input  logic [ADDR_WIDTH-1:0]              addr_a,
    input  logic [ADDR_WIDTH-1:0]              addr_b,
    input  logic [DATA_WIDTH-1:0]              wdata_a,
    input  logic [DATA_WIDTH-1:0]              wdata_b,
    output logic [DATA_WIDTH-1:0]              rdata_a,
    output logic [DATA_WIDTH-1:0]              rdata_b,
    output logic                               rvalid_a,
    output logic                               rvalid_b,
    output logic                               init_busy,
    output logic                               collision
);

    localparam int NBE   = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (!(RD_LATENCY == 1 || RD_LATENCY == 2) || (DATA_WIDTH % BYTE_WIDTH) != 0 ||
        !(RDW_MODE == WRITE_FIRST || RDW_MODE == READ_FIRST)) begin : g_bad_params
        $error("dpram_init: illegal parameter combination");
    end

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] sweep_addr, sweep_addr_nx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  ready, wr_a, wr_b;
    logic [DATA_WIDTH-1:0] old_a, old_b, post_a, post_b, rd_a, rd_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_INIT;
            sweep_addr <= '0;
        end else begin
            state      <= state_nx;
            sweep_addr <= sweep_addr_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        sweep_addr_nx = sweep_addr;
        case (state)
            ST_INIT: begin
                sweep_addr_nx = sweep_addr + 1'b1;
                if (sweep_addr == {ADDR_WIDTH{1'b1}}) begin
                    state_nx = ST_READY;
                end
            end
            ST_READY: begin
                if (clear_req) begin
                    state_nx      = ST_INIT;
                    sweep_addr_nx = '0;
                end
            end
            default: state_nx = ST_INIT;
        endcase
    end

    assign init_busy = (state == ST_INIT);
    assign ready     = (state == ST_READY) && !rst;
    assign wr_a      = ready && en_a && we_a;
    assign wr_b      = ready && en_b && we_b;

    // Final word per port address; at a shared address A owns its lanes and B fills the rest
    always_comb begin
        old_a  = mem[addr_a];
        old_b  = mem[addr_b];
        post_a = old_a;
        post_b = old_b;
        for (int i = 0; i < NBE; i++) begin
            if (wr_b && be_b[i] && addr_b == addr_a) post_a[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata_b[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (wr_a && be_a[i])                     post_a[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (wr_b && be_b[i])                     post_b[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata_b[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (wr_a && be_a[i] && addr_a == addr_b) post_b[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata_a[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_INIT && !rst) begin
            mem[sweep_addr] <= INIT_VALUE;
        end else begin
            if (wr_b) mem[addr_b] <= post_b;
            if (wr_a) mem[addr_a] <= post_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            collision <= 1'b0;
        end else begin
            collision <= wr_a && wr_b && (addr_a == addr_b) && (|(be_a & be_b));
        end
    end

    assign rd_a = (we_a && RDW_MODE == WRITE_FIRST) ? post_a : old_a;
    assign rd_b = (we_b && RDW_MODE == WRITE_FIRST) ? post_b : old_b;

    dpram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .RD_LATENCY(RD_LATENCY)) u_pipe_a (
        .clk      (clk),
        .rst      (rst),
        .in_valid (ready && en_a),
        .in_data  (rd_a),
        .rvalid   (rvalid_a),
        .rdata    (rdata_a)
    );

    dpram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .RD_LATENCY(RD_LATENCY)) u_pipe_b (
        .clk      (clk),
        .rst      (rst),
        .in_valid (ready && en_b),
        .in_data  (rd_b),
        .rvalid   (rvalid_b),
        .rdata    (rdata_b)
    );

endmodule

// File: tb/tb_dpram_init.sv
// tb/tb_dpram_init.sv - bench for dpram_init: write-first/latency-1 and read-first/latency-2 instances
module tb_dpram_init;

    localparam logic [31:0] INIT1 = 32'hC3C3_C3C3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, clear_req = 1'b0;
    logic        en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
    logic [3:0]  be_a = '0, be_b = '0;
    logic [5:0]  addr_a = '0, addr_b = '0;
    logic [31:0] wdata_a = '0, wdata_b = '0;

    logic [31:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
    logic        rvalid_a0, rvalid_b0, rvalid_a1, rvalid_b1;
    logic        init_busy0, init_busy1, collision0, collision1;

    dpram_init #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .BYTE_WIDTH(8), .RD_LATENCY(1),
                 .RDW_MODE(0), .INIT_VALUE(32'h0)) u_dut0 (
        .clk(clk), .rst(rst), .clear_req(clear_req),
        .en_a(en_a), .en_b(en_b), .we_a(we_a), .we_b(we_b), .be_a(be_a), .be_b(be_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .rdata_a(rdata_a0), .rdata_b(rdata_b0), .rvalid_a(rvalid_a0), .rvalid_b(rvalid_b0),
        .init_busy(init_busy0), .collision(collision0)
    );

    dpram_init #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .BYTE_WIDTH(8), .RD_LATENCY(2),
                 .RDW_MODE(1), .INIT_VALUE(INIT1)) u_dut1 (
        .clk(clk), .rst(rst), .clear_req(clear_req),
        .en_a(en_a), .en_b(en_b), .we_a(we_a), .we_b(we_b), .be_a(be_a), .be_b(be_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .rdata_a(rdata_a1), .rdata_b(rdata_b1), .rvalid_a(rvalid_a1), .rvalid_b(rvalid_b1),
        .init_busy(init_busy1), .collision(collision1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: memory image, sweep position and a list of pending read results per port
    logic [31:0] mm [2][64];
    bit          mbusy [2];
    int          maddr [2];
    bit          hv [2][2][2];
    logic [31:0] hd [2][2][2];
    logic [31:0] mrd [2][2];
    bit          mrv [2][2];
    bit          mcol [2];

    typedef struct {
        logic        en_b;
        logic [3:0]  be_a, be_b;
        logic [5:0]  addr_a, addr_b;
        logic [31:0] wd_a, wd_b;
        logic [5:0]  chk_addr;
        logic [31:0] exp0, exp1;
        logic        exp_col;
    } vec_t;
    vec_t vecs [6];

    logic [31:0] d0, d1, e0, e1;
    logic [4:0]  vpat;
    logic [31:0] got [$];

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d, input logic [3:0] be);
        for (int i = 0; i < 4; i++) if (be[i]) w[i*8 +: 8] = d[i*8 +: 8];
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit          nv [2];
            logic [31:0] nd [2];
            logic [31:0] nm [64];
            int          lat;
            lat = (k == 0) ? 1 : 2;
            nv[0] = 0; nv[1] = 0; nd[0] = '0; nd[1] = '0;
            mcol[k] = 0;
            if (rst) begin
                mbusy[k] = 1; maddr[k] = 0;
                for (int p = 0; p < 2; p++) begin
                    mrv[k][p] = 0; mrd[k][p] = '0;
                    for (int s = 0; s < 2; s++) begin hv[k][p][s] = 0; hd[k][p][s] = '0; end
                end
            end else begin
                if (mbusy[k]) begin
                    mm[k][maddr[k]] = (k == 0) ? 32'h0 : INIT1;
                    if (maddr[k] == 63) mbusy[k] = 0; else maddr[k]++;
                end else begin
                    for (int i = 0; i < 64; i++) nm[i] = mm[k][i];
                    if (en_b && we_b) nm[addr_b] = merge(nm[addr_b], wdata_b, be_b);
                    if (en_a && we_a) nm[addr_a] = merge(nm[addr_a], wdata_a, be_a);
                    nv[0] = en_a; nv[1] = en_b;
                    nd[0] = (k == 0 && we_a) ? nm[addr_a] : mm[k][addr_a];
                    nd[1] = (k == 0 && we_b) ? nm[addr_b] : mm[k][addr_b];
                    mcol[k] = en_a && we_a && en_b && we_b && addr_a == addr_b && (be_a & be_b) != 0;
                    for (int i = 0; i < 64; i++) mm[k][i] = nm[i];
                    if (clear_req) begin mbusy[k] = 1; maddr[k] = 0; end
                end
                for (int p = 0; p < 2; p++) begin
                    hv[k][p][1] = hv[k][p][0]; hv[k][p][0] = nv[p];
                    hd[k][p][1] = hd[k][p][0]; hd[k][p][0] = nd[p];
                    mrv[k][p] = hv[k][p][lat-1];
                    if (hv[k][p][lat-1]) mrd[k][p] = hd[k][p][lat-1];
                end
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("busy0",  32'(init_busy0), 32'(mbusy[0]));
        chk("col0",   32'(collision0), 32'(mcol[0]));
        chk("rv_a0",  32'(rvalid_a0),  32'(mrv[0][0]));
        chk("rv_b0",  32'(rvalid_b0),  32'(mrv[0][1]));
        chk("rd_a0",  rdata_a0,        mrd[0][0]);
        chk("rd_b0",  rdata_b0,        mrd[0][1]);
        chk("busy1",  32'(init_busy1), 32'(mbusy[1]));
        chk("col1",   32'(collision1), 32'(mcol[1]));
        chk("rv_a1",  32'(rvalid_a1),  32'(mrv[1][0]));
        chk("rv_b1",  32'(rvalid_b1),  32'(mrv[1][1]));
        chk("rd_a1",  rdata_a1,        mrd[1][0]);
        chk("rd_b1",  rdata_b1,        mrd[1][1]);
    endtask

    task automatic idle_inputs();
        en_a = 0; we_a = 0; en_b = 0; we_b = 0; be_a = '0; be_b = '0;
    endtask

    task automatic count_busy(input string nm);
        int n;
        n = 0;
        while (init_busy0 && n < 200) begin cyc(); n++; end
        chk(nm, n, 64);
    endtask

    task automatic rd_a(input logic [5:0] a, output logic [31:0] r0, output logic [31:0] r1);
        idle_inputs(); en_a = 1; addr_a = a; cyc();
        en_a = 0; cyc();
        r0 = rdata_a0; r1 = rdata_a1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 4'b0101, 4'b0000, 6'd1,  6'd0,  32'hAABBCCDD, 32'h0,        6'd1,  32'h00BB00DD, 32'hC3BBC3DD, 1'b0};
        vecs[1] = '{1'b1, 4'b1111, 4'b1111, 6'd7,  6'd7,  32'h00000012, 32'h00000034, 6'd7,  32'h00000012, 32'h00000012, 1'b1};
        vecs[2] = '{1'b1, 4'b0011, 4'b1100, 6'd8,  6'd8,  32'h1111AAAA, 32'hBBBB2222, 6'd8,  32'hBBBBAAAA, 32'hBBBBAAAA, 1'b0};
        vecs[3] = '{1'b1, 4'b0110, 4'b0011, 6'd9,  6'd9,  32'h11223344, 32'h55667788, 6'd9,  32'h00223388, 32'hC3223388, 1'b1};
        vecs[4] = '{1'b1, 4'b1111, 4'b1111, 6'd10, 6'd11, 32'h01020304, 32'h0A0B0C0D, 6'd11, 32'h0A0B0C0D, 32'h0A0B0C0D, 1'b0};
        vecs[5] = '{1'b1, 4'b0000, 4'b1111, 6'd12, 6'd12, 32'hFFFFFFFF, 32'h99999999, 6'd12, 32'h99999999, 32'h99999999, 1'b0};

        // reset then full init sweep
        rst = 1; cyc(); cyc();
        rst = 0;
        count_busy("init_len");

        // every address reads back the init value on both ports
        for (int a = 0; a < 64; a++) begin
            en_a = 1; addr_a = 6'(a); en_b = 1; addr_b = 6'(63 - a); cyc();
        end
        idle_inputs(); cyc(); cyc();
        rd_a(6'd40, d0, d1);
        chk("init_word0", d0, 32'h0);
        chk("init_word1", d1, INIT1);

        // directed lane / collision vectors
        foreach (vecs[i]) begin
            en_a = 1; we_a = 1; be_a = vecs[i].be_a; addr_a = vecs[i].addr_a; wdata_a = vecs[i].wd_a;
            en_b = vecs[i].en_b; we_b = 1; be_b = vecs[i].be_b; addr_b = vecs[i].addr_b; wdata_b = vecs[i].wd_b;
            cyc();
            chk($sformatf("vec%0d_col0", i), 32'(collision0), 32'(vecs[i].exp_col));
            chk($sformatf("vec%0d_col1", i), 32'(collision1), 32'(vecs[i].exp_col));
            idle_inputs(); cyc();
            chk($sformatf("vec%0d_col_pulse", i), 32'(collision0), 32'h0);
            rd_a(vecs[i].chk_addr, d0, d1);
            chk($sformatf("vec%0d_data0", i), d0, vecs[i].exp0);
            chk($sformatf("vec%0d_data1", i), d1, vecs[i].exp1);
        end

        // read-during-write on port A with a cross-port read of the same word
        idle_inputs(); en_a = 1; we_a = 1; be_a = 4'hF; addr_a = 6'd20; wdata_a = 32'h11; cyc();
        wdata_a = 32'h5A; en_b = 1; addr_b = 6'd20; cyc();
        e0 = rdata_a0; e1 = rdata_b0;
        idle_inputs(); cyc();
        chk("rdw_wf_a", e0, 32'h5A);
        chk("rdw_cross_b0", e1, 32'h11);
        chk("rdw_rf_a", rdata_a1, 32'h11);
        chk("rdw_cross_b1", rdata_b1, 32'h11);
        rd_a(6'd20, d0, d1);
        chk("rdw_stored", d1, 32'h5A);

        // back-to-back reads under latency 2
        for (int i = 1; i <= 3; i++) begin
            en_a = 1; we_a = 1; be_a = 4'hF; addr_a = 6'(i); wdata_a = 32'h101 * i; cyc();
        end
        idle_inputs(); cyc(); cyc();
        got.delete();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin en_a = 1; addr_a = 6'(i + 1); end else en_a = 0;
            cyc();
            vpat[i] = rvalid_a1;
            if (rvalid_a1) got.push_back(rdata_a1);
        end
        chk("lat2_pattern", 32'(vpat), 32'b01110);
        chk("lat2_count", got.size(), 3);
        for (int j = 0; j < got.size() && j < 3; j++) chk($sformatf("lat2_data%0d", j), got[j], 32'h101 * (j + 1));

        // clear_req in READY: same-cycle access still happens, then contents return to init
        idle_inputs(); en_a = 1; we_a = 1; be_a = 4'hF; addr_a = 6'd5; wdata_a = 32'hFEEDFACE; cyc();
        we_a = 0; en_b = 1; we_b = 1; be_b = 4'hF; addr_b = 6'd6; wdata_b = 32'h12345678;
        clear_req = 1; cyc();
        chk("clr_rvalid", 32'(rvalid_a0), 32'h1);
        chk("clr_rdata", rdata_a0, 32'hFEEDFACE);
        clear_req = 0; idle_inputs();
        count_busy("clear_len");
        rd_a(6'd5, d0, d1);
        chk("clr_word5_0", d0, 32'h0);
        chk("clr_word5_1", d1, INIT1);
        rd_a(6'd6, d0, d1);
        chk("clr_word6_1", d1, INIT1);

        // reset partway through a sweep, with clear_req held while sweeping
        rst = 1; cyc(); rst = 0;
        repeat (30) cyc();
        rst = 1; cyc(); rst = 0;
        clear_req = 1;
        count_busy("midsweep_len");
        clear_req = 0;

        // randomized traffic on a small address window to provoke collisions
        for (int c = 0; c < 600; c++) begin
            en_a = 1'($urandom_range(0, 1)); we_a = 1'($urandom_range(0, 1));
            en_b = 1'($urandom_range(0, 1)); we_b = 1'($urandom_range(0, 1));
            be_a = 4'($urandom); be_b = 4'($urandom);
            addr_a = 6'($urandom_range(0, 7)); addr_b = 6'($urandom_range(0, 7));
            wdata_a = $urandom; wdata_b = $urandom;
            clear_req = ($urandom_range(0, 99) == 0);
            rst = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 0; clear_req = 0; idle_inputs(); cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
